// File: rtl/alu_result_buffer.sv
// Purpose : FWFT result buffer between the 12-bit fixed-point ALU and a back-pressuring consumer.
// Latency : one cycle from an accepted push to o_valid/o_data; head data is combinational from the array.
// Backpr. : consumer stalls via i_ready; the ALU cannot be stalled, so pushes into a full buffer
//           (with no pop that cycle) are discarded and flagged on the sticky o_drop.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_valid/i_data/i_overflow ALU result push request
//   i_clear                  synchronous flush (pointers, count, drop flag, statistics)
//   i_ready                  consumer ready; pop = o_valid & i_ready
//   o_valid/o_data/o_overflow head entry
//   o_count, o_full, o_drop  occupancy, full flag, sticky discard flag
//   o_ovf_cnt                saturating count of accepted pushes with overflow set
//
// Optional feature macro: ALU_RESBUF_STATS_EN enables the o_ovf_cnt counter;
// when undefined o_ovf_cnt is tied to zero.

module alu_result_buffer #(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 12,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_overflow,
    input  logic              i_clear,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_overflow,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_drop,
    output logic [7:0]        o_ovf_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Each entry is {overflow, data}.
    logic [DATA_W:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;

    logic full;
    logic pop;
    logic push_acc;
    logic push_drop;

    assign full      = (count_q == CW'(DEPTH));
    assign o_valid   = (count_q != '0);
    assign pop       = o_valid & i_ready;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_acc  = i_valid & (~full | pop);
    assign push_drop = i_valid & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (i_clear) begin
            // Flush wins over any push or pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push_acc, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_drop) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array is deliberately not reset or cleared; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_acc && !i_clear) begin
            mem_q[wr_ptr_q] <= {i_overflow, i_data};
        end
    end

    assign o_data     = mem_q[rd_ptr_q][DATA_W-1:0];
    assign o_overflow = mem_q[rd_ptr_q][DATA_W];
    assign o_count    = count_q;
    assign o_full     = full;
    assign o_drop     = drop_q;

`ifdef ALU_RESBUF_STATS_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Counts accepted pushes only; saturates rather than wrapping.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (i_clear) begin
            ovf_cnt_d = '0;
        end else if (push_acc && i_overflow && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_ovf_cnt = ovf_cnt_q;
`else
    assign o_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [11:0] i_data;
    logic        i_overflow;
    logic        i_clear;
    logic        i_ready;
    logic        o_valid;
    logic [11:0] o_data;
    logic        o_overflow;
    logic [3:0]  o_count;
    logic        o_full;
    logic        o_drop;
    logic [7:0]  o_ovf_cnt;

    int checks = 0;
    int errors = 0;

    // Expected {overflow, data} of every entry the DUT should deliver, in order.
    logic [12:0] exp_q[$];

`ifdef ALU_RESBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    alu_result_buffer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_overflow (i_overflow),
        .i_clear    (i_clear),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_overflow (o_overflow),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_drop     (o_drop),
        .o_ovf_cnt  (o_ovf_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the clock edge.
    task automatic step(input logic v, input logic [11:0] d, input logic ov,
                        input logic rdy, input logic clr);
        i_valid    = v;
        i_data     = d;
        i_overflow = ov;
        i_ready    = rdy;
        i_clear    = clr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_exp(input logic [11:0] d, input logic ov);
        exp_q.push_back({ov, d});
    endtask

    // Monitor: on the falling edge, a visible handshake means the head leaves at the next edge.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready && !i_clear) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got data 0x%0h, want no entry", o_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("pop_data", int'(o_data), int'(e[11:0]));
                chk("pop_ovf", int'(o_overflow), int'(e[12]));
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0; i_data = '0; i_overflow = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_full", int'(o_full), 0);
        chk("rst_drop", int'(o_drop), 0);
        chk("rst_ovf_cnt", int'(o_ovf_cnt), 0);
        i_rst_n = 1'b1;
        step(0, 12'h000, 0, 0, 0);

        // Single push, then single pop.
        push_exp(12'h123, 0);
        step(1, 12'h123, 0, 0, 0);
        chk("single_valid", int'(o_valid), 1);
        chk("single_data", int'(o_data), 'h123);
        chk("single_count", int'(o_count), 1);
        step(0, 12'h000, 0, 1, 0);
        chk("single_pop_valid", int'(o_valid), 0);
        chk("single_pop_count", int'(o_count), 0);

        // Overfill: 8 accepted, the 9th dropped.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) push_exp(12'(i), 0);
            step(1, 12'(i), 0, 0, 0);
            if (i == 7) chk("fill7_full", int'(o_full), 0);
            if (i == 8) begin
                chk("fill8_full", int'(o_full), 1);
                chk("fill8_drop", int'(o_drop), 0);
            end
        end
        chk("over_drop", int'(o_drop), 1);
        chk("over_count", int'(o_count), 8);
        for (int i = 0; i < 8; i++) step(0, 12'h000, 0, 1, 0);
        chk("drain_valid", int'(o_valid), 0);
        chk("drain_sb", exp_q.size(), 0);
        chk("drain_drop_sticky", int'(o_drop), 1);
        step(0, 12'h000, 0, 0, 1);
        chk("clear_drop", int'(o_drop), 0);

        // Push into full buffer while popping.
        for (int i = 1; i <= 8; i++) begin
            push_exp(12'h100 + 12'(i), 0);
            step(1, 12'h100 + 12'(i), 0, 0, 0);
        end
        push_exp(12'h7FF, 0);
        step(1, 12'h7FF, 0, 1, 0);
        chk("fullpp_count", int'(o_count), 8);
        chk("fullpp_drop", int'(o_drop), 0);
        for (int i = 0; i < 8; i++) step(0, 12'h000, 0, 1, 0);
        chk("fullpp_drain_sb", exp_q.size(), 0);
        chk("fullpp_drain_valid", int'(o_valid), 0);

        // Clear has priority over a simultaneous push and pop.
        for (int i = 1; i <= 5; i++) begin
            push_exp(12'h200 + 12'(i), 0);
            step(1, 12'h200 + 12'(i), 0, 0, 0);
        end
        chk("fill5_count", int'(o_count), 5);
        step(1, 12'h3AA, 0, 1, 1);
        exp_q.delete();
        chk("clr_count", int'(o_count), 0);
        chk("clr_valid", int'(o_valid), 0);
        chk("clr_drop", int'(o_drop), 0);
        push_exp(12'h0AB, 1);
        step(1, 12'h0AB, 1, 0, 0);
        chk("post_clr_count", int'(o_count), 1);
        chk("post_clr_data", int'(o_data), 'h0AB);
        step(0, 12'h000, 0, 1, 0);
        step(0, 12'h000, 0, 0, 1);

        // Continuous streaming with pointer wrap.
        for (int i = 0; i < 20; i++) begin
            push_exp(12'(i), 0);
            step(1, 12'(i), 0, 1, 0);
            chk("wrap_cnt_le1", int'(o_count <= 4'd1), 1);
            chk("wrap_head", int'(o_data), i);
        end
        step(0, 12'h000, 0, 1, 0);
        chk("wrap_sb", exp_q.size(), 0);
        chk("wrap_valid", int'(o_valid), 0);

        // Statistics: drops do not count.
        step(0, 12'h000, 0, 0, 1);
        chk("stat_clr", int'(o_ovf_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            push_exp(12'h400 + 12'(i), 1);
            step(1, 12'h400 + 12'(i), 1, 0, 0);
        end
        step(1, 12'h4FF, 1, 0, 0);
        chk("stat_drop_flag", int'(o_drop), 1);
        chk("stat_after_drop", int'(o_ovf_cnt), STATS ? 8 : 0);
        for (int i = 0; i < 8; i++) step(0, 12'h000, 0, 1, 0);
        step(0, 12'h000, 0, 0, 1);
        chk("stat_clr2", int'(o_ovf_cnt), 0);

        // Statistics saturation.
        for (int i = 0; i < 300; i++) begin
            push_exp(12'(i), 1);
            step(1, 12'(i), 1, 1, 0);
            if (i == 254) chk("stat_255", int'(o_ovf_cnt), STATS ? 255 : 0);
        end
        step(0, 12'h000, 0, 1, 0);
        chk("stat_sat", int'(o_ovf_cnt), STATS ? 255 : 0);
        chk("stat_sb", exp_q.size(), 0);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) step(1, 12'h500 + 12'(i), 0, 0, 0);
        chk("pre_rst_count", int'(o_count), 3);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(o_valid), 0);
        chk("async_rst_count", int'(o_count), 0);
        chk("async_rst_ovf", int'(o_ovf_cnt), 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(0, 12'h000, 0, 1, 0);
        chk("after_rst_valid", int'(o_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Result buffer directly downstream of the 12-bit fixed-point ALU. It captures every ALU result and overflow flag whenever the ALU asserts its valid. It queues them in a first-word-fall-through FIFO and presents them to a back-pressuring consumer through a valid/ready handshake. The ALU has no stall input, so pushes that arrive while the buffer is full are discarded and recorded in a sticky drop flag.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 2
- DATA_W, 12, result width; matches the ALU data output
- CW, $clog2(DEPTH)+1, count width (derived, not overridden)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  ALU result valid (push request)
- i_data  input  DATA_W  ALU result
- i_overflow  input  1  ALU overflow flag for i_data
- i_clear  input  1  synchronous flush
- i_ready  input  1  consumer ready (pop when o_valid is also high)
- o_valid  output  1  head entry valid (equals count != 0)
- o_data  output  DATA_W  head entry data
- o_overflow  output  1  head entry overflow flag
- o_count  output  CW  occupancy, 0..DEPTH
- o_full  output  1  count == DEPTH
- o_drop  output  1  sticky: a push was discarded since the last reset or clear
- o_ovf_cnt  output  8  overflow statistics (see Configuration)

## Operation
- Storage: DEPTH × (DATA_W+1) array plus write pointer, read pointer and occupancy counter.
  - Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- Push = i_valid. The push is accepted when count < DEPTH, or when count == DEPTH and a pop happens in the same cycle.
  - An accepted push writes {i_overflow, i_data} at the write pointer.
- Pop = o_valid & i_ready. It advances the read pointer.
  - i_ready while empty has no effect.
- Count rules:
  - push only: +1.
  - pop only: −1.
  - simultaneous accepted push and pop: unchanged.
  - push while empty with i_ready high: no pop (o_valid was low); count becomes 1.
- Drop: i_valid & full & no pop. Data is discarded, and pointers and count are unchanged.
  - o_drop is set next cycle and stays high until reset or i_clear.
- o_data/o_overflow are driven combinationally from the array at the read pointer. They are don't-care while o_valid is low; the bench must not check them then.
- i_clear has priority over push and pop in the same cycle.
  - Pointers, count and o_drop go to 0.
  - Statistics are cleared.
  - Array contents are not cleared.
- No state machine beyond the counter: empty (count 0), partial, full (count DEPTH).

## Timing
- Reset (asynchronous assert, registered release) drives:
  - pointers = 0, count = 0, o_valid = 0, o_full = 0, o_drop = 0, o_ovf_cnt = 0.
  - o_data and o_overflow read array slot 0, which is unspecified.
- Push-to-output latency is one cycle: a push at edge N gives o_valid = 1 with that data after edge N.
- Pop takes effect at the edge where o_valid & i_ready is sampled high. The next entry, or o_valid = 0, is visible after that edge.
- Back-to-back push every cycle with i_ready held high sustains throughput of 1 entry per cycle with count ≤ 1.
- Reset asserted mid-operation empties the buffer immediately (asynchronously); in-flight entries are lost.

## Configuration
- Macro: ALU_RESBUF_STATS_EN.
- Defined:
  - o_ovf_cnt counts accepted pushes with i_overflow = 1.
  - It increments once per accepted push and saturates at 255.
  - Dropped pushes are not counted.
  - It is cleared by reset and by i_clear.
- Not defined: o_ovf_cnt is tied to 0, and no counter logic is synthesized. All other behaviour is identical.

## Test plan
- Reset, then push 0x123 (ovf 0) with i_ready = 0:
  - next cycle o_valid = 1, o_data = 0x123, o_count = 1.
  - then i_ready = 1 for one cycle → o_valid = 0, o_count = 0.
- Push 9 values 0x001..0x009 with i_ready = 0 (DEPTH = 8):
  - o_full = 1 after the 8th push.
  - o_drop = 1 after the 9th push.
  - draining yields 0x001..0x008 in order; 0x009 is never seen.
- At full, push 0x7FF in the same cycle as a pop:
  - push accepted, o_count stays 8, o_drop stays 0.
  - drain ends with 0x7FF.
- Fill to 5, then assert i_clear together with i_valid and i_ready:
  - o_count = 0, o_valid = 0, o_drop = 0.
  - the pushed value is not stored.
- Wrap-around: 20 cycles of continuous push and pop with i_ready = 1, data = cycle index:
  - outputs appear in order with one-cycle delay.
  - o_count ≤ 1 throughout.
- With ALU_RESBUF_STATS_EN defined:
  - 300 accepted pushes with ovf = 1 → o_ovf_cnt = 255.
  - a dropped push with ovf = 1 does not increment it.
  - without the macro, o_ovf_cnt = 0 throughout.
